// File: rtl/load_store_unit.sv
// Memory-access stage: takes a load/store with a precomputed effective address,
// drives a single-outstanding req/gnt/rvalid data-memory port with byte strobes,
// and returns aligned, sign/zero-extended load data for writeback. Misaligned
// and illegal-width accesses raise a one-cycle exception pulse instead of issuing.
module load_store_unit #(
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic                 ex_is_load,
    input  logic                 ex_is_store,
    input  logic [2:0]           ex_funct3,
    input  logic [WIDTH-1:0]     ex_addr,
    input  logic [WIDTH-1:0]     ex_wdata,
    input  logic [REG_WIDTH-1:0] ex_rd,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [3:0]           mem_wstrb,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 wb_valid,
    output logic [REG_WIDTH-1:0] wb_rd,
    output logic [WIDTH-1:0]     wb_data,
    output logic                 store_done,
    output logic                 exc_misaligned,
    output logic                 exc_illegal,
    output logic [WIDTH-1:0]     exc_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t               state_r;
    logic                 is_load_r;
    logic [2:0]           funct3_r;
    logic [1:0]           offset_r;
    logic [REG_WIDTH-1:0] rd_r;

    logic                 accept_s;
    logic                 op_s;
    logic                 illegal_s;
    logic                 misaligned_s;
    logic [3:0]           wstrb_s;
    logic [WIDTH-1:0]     wdata_s;

    // Legal width encodings: loads allow B/H/W/BU/HU, stores only B/H/W.
    function automatic logic legal_f(input logic is_load, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = is_load;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] extract_f(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    assign ex_ready = (state_r == IDLE);
    assign accept_s = ex_valid && (state_r == IDLE);

    // Decode the presented op: fault checks plus store lane placement.
    always_comb begin
        op_s         = ex_is_load || ex_is_store;
        illegal_s    = !legal_f(ex_is_load, ex_funct3);
        misaligned_s = 1'b0;
        wstrb_s      = 4'b0000;
        wdata_s      = {WIDTH{1'b0}};
        case (ex_funct3[1:0])
            2'b01:   misaligned_s = ex_addr[0];
            2'b10:   misaligned_s = (ex_addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        case (ex_funct3[1:0])
            2'b00: begin
                wstrb_s = 4'b0001 << ex_addr[1:0];
                wdata_s = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                wstrb_s = 4'b0011 << ex_addr[1:0];
                wdata_s = {2{ex_wdata[15:0]}};
            end
            2'b10: begin
                wstrb_s = 4'b1111;
                wdata_s = ex_wdata;
            end
            default: begin
                wstrb_s = 4'b0000;
                wdata_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Access FSM with registered memory, writeback and exception outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            is_load_r      <= 1'b0;
            funct3_r       <= 3'b000;
            offset_r       <= 2'b00;
            rd_r           <= {REG_WIDTH{1'b0}};
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= {WIDTH{1'b0}};
            mem_wstrb      <= 4'b0000;
            mem_wdata      <= {WIDTH{1'b0}};
            wb_valid       <= 1'b0;
            wb_rd          <= {REG_WIDTH{1'b0}};
            wb_data        <= {WIDTH{1'b0}};
            store_done     <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_illegal    <= 1'b0;
            exc_addr       <= {WIDTH{1'b0}};
        end else begin
            wb_valid       <= 1'b0;
            store_done     <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_illegal    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && op_s) begin
                        if (illegal_s) begin
                            exc_illegal <= 1'b1;
                            exc_addr    <= ex_addr;
                        end else if (misaligned_s) begin
                            exc_misaligned <= 1'b1;
                            exc_addr       <= ex_addr;
                        end else begin
                            state_r   <= REQ;
                            is_load_r <= ex_is_load;
                            funct3_r  <= ex_funct3;
                            offset_r  <= ex_addr[1:0];
                            rd_r      <= ex_rd;
                            mem_req   <= 1'b1;
                            mem_we    <= !ex_is_load;
                            mem_addr  <= {ex_addr[WIDTH-1:2], 2'b00};
                            mem_wstrb <= ex_is_load ? 4'b0000 : wstrb_s;
                            mem_wdata <= ex_is_load ? {WIDTH{1'b0}} : wdata_s;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (is_load_r) begin
                            state_r <= WAIT_R;
                        end else begin
                            state_r    <= IDLE;
                            store_done <= 1'b1;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        state_r  <= IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_r;
                        wb_data  <= extract_f(mem_rdata, funct3_r, offset_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that sits downstream of the execute stage in the RISC-V core. It accepts a load/store whose effective address the execute ALU has already computed (`rs1 + imm`). It drives a single-outstanding request/grant/response data-memory port with byte lanes and strobes. Load data is aligned and sign/zero-extended for writeback. Misaligned and illegal-width accesses are flagged instead of being issued.

## Interface
- `WIDTH`, 32: data/address width (only 32 supported)
- `REG_WIDTH`, 5: destination register index width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `ex_valid`  in  1  execute stage presents an op
- `ex_ready`  out  1  unit can accept; equals (state==IDLE)
- `ex_is_load`  in  1  op is a load (priority over `ex_is_store`)
- `ex_is_store`  in  1  op is a store
- `ex_funct3`  in  3  LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- `ex_addr`  in  WIDTH  effective byte address from execute `result`
- `ex_wdata`  in  WIDTH  store data (rs2 value)
- `ex_rd`  in  REG_WIDTH  load destination register
- `mem_req`  out  1  request valid, held until granted
- `mem_we`  out  1  1 = write
- `mem_addr`  out  WIDTH  word address, `{ex_addr[31:2],2'b00}`
- `mem_wstrb`  out  4  byte-lane write enables
- `mem_wdata`  out  WIDTH  lane-replicated store data
- `mem_gnt`  in  1  memory accepts request this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  WIDTH  read word
- `wb_valid`  out  1  one-cycle load writeback pulse
- `wb_rd`  out  REG_WIDTH  writeback register
- `wb_data`  out  WIDTH  extended load result
- `store_done`  out  1  one-cycle pulse, store granted
- `exc_misaligned`  out  1  one-cycle pulse
- `exc_illegal`  out  1  one-cycle pulse (bad funct3)
- `exc_addr`  out  WIDTH  faulting address, held until next exception

## Operation
- States: IDLE, REQ, WAIT_R.
- Accept occurs when `ex_valid && ex_ready`. Addr, funct3, rd, and wdata are registered on accept.
- An op with neither load nor store set is consumed with no action.
- Checks at accept:
  - Illegal: funct3 not in the legal list for the op → `exc_illegal`.
  - Misaligned: halfword with addr[0]≠0, or word with addr[1:0]≠0 → `exc_misaligned`.
  - If both apply, illegal wins.
  - On a fault: no request is issued, state stays IDLE, `exc_addr`=ex_addr.
- Legal op: IDLE→REQ.
- REQ: `mem_req`=1. On `mem_gnt`:
  - Store → IDLE, with `store_done` next cycle.
  - Load → WAIT_R.
- WAIT_R: on `mem_rvalid` → IDLE.
  - Next cycle: `wb_valid`=1, `wb_rd`=latched rd, `wb_data`=extracted data.
  - Extraction: byte lane addr[1:0] or half lane addr[1].
  - Sign-extended for LB/LH; zero-extended for LBU/LHU; whole word for LW.
- Store lanes:
  - SB: wstrb=`0001<<addr[1:0]`, wdata={4{b}}.
  - SH: wstrb=`0011<<addr[1:0]`, wdata={2{h}}.
  - SW: wstrb=1111.
  - For loads, `mem_we`=0 and wstrb=0000.
- rd=0 loads are still issued and written back with `wb_rd`=0; the register file discards them.
- `mem_rvalid` outside WAIT_R is ignored.

## Timing
- Reset values: state IDLE, `ex_ready`=1. All other outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`, `wb_valid`, `wb_rd`, `wb_data`, `store_done`, both exc pulses, `exc_addr`.
- Reset mid-op (REQ or WAIT_R): the next edge forces IDLE and drops `mem_req`. Pending writeback is lost, and a later `rvalid` is ignored.
- Accept at edge N → `mem_req` high from cycle N+1. All `mem_*` outputs stay stable while `mem_req`=1 and not granted.
- `mem_gnt` in the same cycle as `mem_req` is allowed: zero-wait grant.
- `mem_rvalid` arrives no earlier than the cycle after `gnt`.
- Minimum latencies, counted from the accept edge:
  - Store: `store_done` 2 cycles after accept.
  - Load: `wb_valid` 3 cycles after accept.
- Exception pulses are asserted in the cycle after accept.
- `ex_ready` deasserts from the cycle after a legal accept and reasserts in the cycle the state returns to IDLE.
- No back-to-back overlap: there is a single outstanding access.

## Test plan
- Reset, then idle → every output 0 and `ex_ready`=1. Then SW addr 0x100, data 0xDEADBEEF, zero-wait gnt → `mem_addr`=0x100, wstrb=1111, `store_done` 2 cycles after accept.
- SB addr 0x203, data 0x000000A5 → wstrb=1000, wdata=0xA5A5A5A5. SH addr 0x202, data 0x1234 → wstrb=1100, wdata=0x12341234.
- LB addr 0x301 with rdata 0x0000_80_00, gnt delayed 3 cycles, rvalid 2 cycles later → `wb_data`=0xFFFFFF80. Repeat as LBU → 0x00000080. LH addr 0x302 with rdata 0x8001_0000 → 0xFFFF8001.
- LW addr 0x102 → `exc_misaligned` pulse, `exc_addr`=0x102, `mem_req` never asserts, `ex_ready` stays 1. LOAD funct3=011 → `exc_illegal`.
- LW issued, reset asserted in WAIT_R, rvalid arrives afterward → `wb_valid` never pulses, state IDLE.
- Stray `mem_rvalid` while IDLE → no `wb_valid`. Op with ex_valid and neither load nor store set → consumed, no memory activity.
